// File: rtl/serial_arith_pkg.sv
// Shared types and constants for the digit-serial arithmetic datapath.
//   mode_e          : per-word operation select (add / subtract)
//   DIGIT_W_DEFAULT : default digit width in bits
package serial_arith_pkg;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_e;

  localparam int unsigned DIGIT_W_DEFAULT = 4;

endpackage

// File: rtl/digit_addsub.sv
// Combinational single-digit adder/subtractor slice.
// Ports:
//   a, b  : operand digits (DIGIT_W bits)
//   cin   : carry into this digit
//   mode  : MODE_ADD computes a+b+cin, MODE_SUB computes a+~b+cin
//   s     : result digit
//   c     : carry out of this digit
//   v     : two's-complement overflow if this digit is the most-significant one
module digit_addsub
  import serial_arith_pkg::*;
#(
  parameter int unsigned DIGIT_W = DIGIT_W_DEFAULT
) (
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               cin,
  input  mode_e              mode,
  output logic [DIGIT_W-1:0] s,
  output logic               c,
  output logic               v
);

  logic [DIGIT_W-1:0] b_eff;
  logic [DIGIT_W:0]   full;

  always_comb begin
    b_eff = (mode == MODE_SUB) ? ~b : b;
    full  = {1'b0, a} + {1'b0, b_eff} + {{DIGIT_W{1'b0}}, cin};
    s     = full[DIGIT_W-1:0];
    c     = full[DIGIT_W];
    // Overflow: operands share a sign and the result sign differs from it.
    v     = (a[DIGIT_W-1] == b_eff[DIGIT_W-1]) && (s[DIGIT_W-1] != a[DIGIT_W-1]);
  end

endmodule

// File: rtl/serial_addsub_digit.sv
// Digit-serial adder/subtractor, least-significant digit first, one-cycle latency.
// Ports:
//   clk, rst   : clock (rising edge), asynchronous active-high reset
//   vld        : input digit valid
//   a, b       : operand digits
//   sub        : 0 = A+B, 1 = A-B; sampled on the first valid digit of a word
//   last       : current digit is the word's most-significant digit (only with vld)
//   out_vld    : result digit valid
//   sum        : result digit
//   out_last   : result digit closes the word
//   carry_out  : final carry (add: unsigned overflow; sub: 1 = no borrow)
//   ovf        : signed overflow of the whole word
module serial_addsub_digit
  import serial_arith_pkg::*;
#(
  parameter int unsigned DIGIT_W = DIGIT_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vld,
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               sub,
  input  logic               last,
  output logic               out_vld,
  output logic [DIGIT_W-1:0] sum,
  output logic               out_last,
  output logic               carry_out,
  output logic               ovf
);

  logic               first_q;
  logic               carry_q;
  mode_e              mode_q;

  logic               out_vld_q;
  logic [DIGIT_W-1:0] sum_q;
  logic               out_last_q;
  logic               carry_out_q;
  logic               ovf_q;

  mode_e              eff_mode;
  logic               cin;
  logic [DIGIT_W-1:0] dig_s;
  logic               dig_c;
  logic               dig_v;

  // Mode and carry-in come from the live inputs on a word's first digit.
  always_comb begin
    eff_mode = first_q ? mode_e'(sub) : mode_q;
    cin      = first_q ? (eff_mode == MODE_SUB) : carry_q;
  end

  digit_addsub #(
    .DIGIT_W(DIGIT_W)
  ) u_digit (
    .a   (a),
    .b   (b),
    .cin (cin),
    .mode(eff_mode),
    .s   (dig_s),
    .c   (dig_c),
    .v   (dig_v)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_q     <= 1'b1;
      carry_q     <= 1'b0;
      mode_q      <= MODE_ADD;
      out_vld_q   <= 1'b0;
      sum_q       <= '0;
      out_last_q  <= 1'b0;
      carry_out_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (vld) begin
      out_vld_q <= 1'b1;
      sum_q     <= dig_s;
      if (first_q) begin
        mode_q <= eff_mode;
      end
      if (last) begin
        out_last_q  <= 1'b1;
        carry_out_q <= dig_c;
        ovf_q       <= dig_v;
        first_q     <= 1'b1;
        carry_q     <= 1'b0;
      end else begin
        out_last_q  <= 1'b0;
        carry_out_q <= 1'b0;
        ovf_q       <= 1'b0;
        first_q     <= 1'b0;
        carry_q     <= dig_c;
      end
    end else begin
      // Gap cycle: outputs idle, word state holds.
      out_vld_q   <= 1'b0;
      sum_q       <= '0;
      out_last_q  <= 1'b0;
      carry_out_q <= 1'b0;
      ovf_q       <= 1'b0;
    end
  end

  assign out_vld   = out_vld_q;
  assign sum       = sum_q;
  assign out_last  = out_last_q;
  assign carry_out = carry_out_q;
  assign ovf       = ovf_q;

endmodule

// File: doc/serial_addsub_digit.md
Name: serial_addsub_digit

Overview:
- Digit-serial adder/subtractor. Each valid cycle it consumes one DIGIT_W-bit digit of operands a and b, least-significant digit first.
- Generalises the 1-bit serial adder in three ways: a configurable digit width, a per-word add/sub mode, and registered outputs that carry valid, last, carry-out and signed-overflow flags.
- Sits between serialising front-ends and digit-serial consumers in the sequential-arithmetic datapath.

Parameters:
- DIGIT_W, 4, bits per digit processed per cycle (>=2).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- vld  in  1  input digit valid
- a  in  DIGIT_W  operand A digit
- b  in  DIGIT_W  operand B digit
- sub  in  1  mode: 0 = A+B, 1 = A-B. Sampled only on the first valid digit of a word.
- last  in  1  current digit is the most-significant digit of the word. Honoured only when vld=1.
- out_vld  out  1  output digit valid
- sum  out  DIGIT_W  result digit
- out_last  out  1  result digit is the final digit of the word
- carry_out  out  1  final carry of the word. For add: unsigned overflow. For sub: 1 means no borrow (A>=B unsigned).
- ovf  out  1  two's-complement signed overflow of the whole word

Behaviour:
- Reset: asynchronous and active-high. All outputs are 0. Internal state is cleared: carry_reg=0, first=1, mode_reg=ADD.
- State:
  - first flag: 1 means the next valid digit starts a word.
  - carry_reg: carry between digits.
  - mode_reg: latched mode for the current word.
- Effective mode: sub when first=1, else mode_reg.
- Effective operand: b_eff = b in add mode, ~b in sub mode.
- Carry-in: 1 on the first digit of a sub word, 0 on the first digit of an add word, carry_reg otherwise.
- Digit arithmetic: {c, s} = a + b_eff + cin, computed at DIGIT_W+1 bits.
- Digit overflow: v = (a[MSB]==b_eff[MSB]) && (s[MSB]!=a[MSB]).
- Latency: exactly 1 cycle. Outputs are registered on the clk edge that samples vld=1.
- On a clk edge with vld=1:
  - out_vld<=1, sum<=s.
  - If last=1: out_last<=1, carry_out<=c, ovf<=v, first<=1, carry_reg<=0.
  - If last=0: out_last<=0, carry_out<=0, ovf<=0, carry_reg<=c, first<=0.
  - If first=1: mode_reg<=sub.
- On a clk edge with vld=0:
  - out_vld, sum, out_last, carry_out and ovf are all registered to 0.
  - carry_reg, first and mode_reg hold, so a word may have arbitrary gaps.
- last with vld=0 is ignored.
- sub on a non-first digit is ignored; a mid-word mode change has no effect.
- Single-digit word (vld=1, last=1, first=1): uses cin derived from sub; the word completes in one digit.
- Back-to-back words: the digit after a last digit is a first digit, with no bubble required.
- Reset mid-word: the partial word is discarded and outputs go to 0 immediately (async). The next valid digit starts a new word with no stale carry or mode.
- No word-length limit. Width is implicit: digit count × DIGIT_W.

Decomposition:
- Package serial_arith_pkg:
  - typedef enum logic {MODE_ADD, MODE_SUB} mode_e
  - localparam DIGIT_W_DEFAULT = 4
- One combinational sub-module digit_addsub #(DIGIT_W):
  - inputs: a, b, cin, mode
  - outputs: s, c, v
  - performs the b inversion, the add and the overflow function.
- Top level holds the first/carry/mode registers and the output registers.

Test Plan (DIGIT_W=4):
- Add 0x3C+0x5A, digits (C,A,last=0) then (3,5,last=1), sub=0 -> out sums 6 then 9 one cycle later; second output has out_last=1, carry_out=0, ovf=1 (60+90>127).
- Sub 0x05-0x07, digits (5,7) then (0,0,last=1), sub=1 on the first digit -> sums E then F (0xFE = -2); carry_out=0 (borrow), ovf=0.
- Repeat the add case with 3 vld=0 cycles between digits and last=1 pulsed during a gap -> identical sums and flags; out_vld=0 and all outputs 0 in the gaps; no early termination.
- Sub word 0x00-0x01, toggling sub to 0 on the second digit -> result 0xFF still produced (mode latched), carry_out=0, ovf=0.
- Assert rst asynchronously between the digits of a word that left carry=1, then add 0x01+0x01 -> outputs 0 during rst; sums 2, 0 with carry_out=0 (no stale carry).
- Back-to-back words:
  - single-digit sub 3-3 (vld=1, last=1) followed next cycle by single-digit add 8+8;
  - expected: sum 0, carry_out=1, ovf=0; then sum 0, carry_out=1, ovf=1.
